// File: rtl/seg_bus_capture.sv
// Captures a multiplexed active-low 4-digit 7-segment display bus and reassembles
// the digits into a 16-bit value, with per-digit illegal-pattern flags and a stale timeout.
module seg_bus_capture #(
    parameter int STABLE_CYC  = 4,
    parameter int TIMEOUT_CYC = 65536
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  an,
    input  logic [6:0]  seg,
    input  logic        clr_err,
    output logic [15:0] value,
    output logic        frame_valid,
    output logic [3:0]  digit_err,
    output logic        stale
);

    localparam int              TW        = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0]   TO_MAX    = TW'(TIMEOUT_CYC);
    localparam logic [7:0]      STABLE_M1 = 8'(STABLE_CYC - 1);

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_HOLD} state_e;

    // Returns {legal, nibble}; blank (all segments off) decodes as F.
    function automatic logic [4:0] seg_decode(input logic [6:0] s);
        case (s)
            7'b0000001: seg_decode = 5'h10;
            7'b1001111: seg_decode = 5'h11;
            7'b0010010: seg_decode = 5'h12;
            7'b0000110: seg_decode = 5'h13;
            7'b1001100: seg_decode = 5'h14;
            7'b0100100: seg_decode = 5'h15;
            7'b0100000: seg_decode = 5'h16;
            7'b0001111: seg_decode = 5'h17;
            7'b0000000: seg_decode = 5'h18;
            7'b0000100: seg_decode = 5'h19;
            7'b0001000: seg_decode = 5'h1A;
            7'b1100000: seg_decode = 5'h1B;
            7'b0110001: seg_decode = 5'h1C;
            7'b1000010: seg_decode = 5'h1D;
            7'b0110000: seg_decode = 5'h1E;
            7'b1111111: seg_decode = 5'h1F;
            default:    seg_decode = 5'h00;
        endcase
    endfunction

    function automatic logic is_onehot_low(input logic [3:0] a);
        case (a)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: is_onehot_low = 1'b1;
            default:                            is_onehot_low = 1'b0;
        endcase
    endfunction

    logic [3:0]    an_meta_q, an_sync_q;
    logic [6:0]    seg_meta_q, seg_sync_q;
    logic [10:0]   prev_q;
    state_e        state_q, state_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [15:0]   nib_q, nib_d;
    logic [3:0]    mask_q, mask_d;
    logic [15:0]   value_q, value_d;
    logic          fv_q, fv_d;
    logic [3:0]    err_q, err_d;
    logic [TW-1:0] to_q, to_d;

    logic [10:0] sample;
    logic        changed;
    logic        onehot;
    logic        capture;
    logic [4:0]  dec;
    logic [3:0]  cap_sel;
    logic [3:0]  good_cap;
    logic [3:0]  bad_cap;
    logic        frame_done;

    always_comb begin
        sample   = {an_sync_q, seg_sync_q};
        changed  = (sample != prev_q);
        onehot   = is_onehot_low(an_sync_q);
        state_d  = state_q;
        cnt_d    = cnt_q;
        capture  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (onehot) begin
                    state_d = S_SETTLE;
                    cnt_d   = 8'd1;
                end else begin
                    cnt_d   = 8'd0;
                end
            end
            S_SETTLE: begin
                if (changed) begin
                    if (onehot) begin
                        cnt_d   = 8'd1;
                    end else begin
                        state_d = S_IDLE;
                        cnt_d   = 8'd0;
                    end
                end else if (cnt_q == STABLE_M1) begin
                    // This sample is the STABLE_CYC-th identical one.
                    state_d = S_HOLD;
                    capture = 1'b1;
                end else begin
                    cnt_d   = cnt_q + 8'd1;
                end
            end
            S_HOLD: begin
                if (changed) begin
                    if (onehot) begin
                        state_d = S_SETTLE;
                        cnt_d   = 8'd1;
                    end else begin
                        state_d = S_IDLE;
                        cnt_d   = 8'd0;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 8'd0;
            end
        endcase
    end

    always_comb begin
        dec        = seg_decode(seg_sync_q);
        cap_sel    = ~an_sync_q & {4{capture}};
        good_cap   = cap_sel & {4{dec[4]}};
        bad_cap    = cap_sel & {4{~dec[4]}};
        frame_done = (mask_q == 4'hF);

        nib_d = nib_q;
        for (int i = 0; i < 4; i++) begin
            if (good_cap[i]) begin
                nib_d[4*i +: 4] = dec[3:0];
            end
        end

        // A capture on the frame-completion edge starts the next frame.
        mask_d  = (frame_done ? 4'h0 : mask_q) | good_cap;
        value_d = frame_done ? nib_q : value_q;
        fv_d    = frame_done;
        err_d   = (clr_err ? 4'h0 : err_q) | bad_cap;

        if (frame_done) begin
            to_d = '0;
        end else if (to_q == TO_MAX) begin
            to_d = to_q;
        end else begin
            to_d = to_q + TW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_meta_q  <= 4'hF;
            an_sync_q  <= 4'hF;
            seg_meta_q <= 7'h7F;
            seg_sync_q <= 7'h7F;
            prev_q     <= 11'h7FF;
            state_q    <= S_IDLE;
            cnt_q      <= 8'd0;
            nib_q      <= 16'h0000;
            mask_q     <= 4'h0;
            value_q    <= 16'h0000;
            fv_q       <= 1'b0;
            err_q      <= 4'h0;
            to_q       <= '0;
        end else begin
            an_meta_q  <= an;
            an_sync_q  <= an_meta_q;
            seg_meta_q <= seg;
            seg_sync_q <= seg_meta_q;
            prev_q     <= sample;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            nib_q      <= nib_d;
            mask_q     <= mask_d;
            value_q    <= value_d;
            fv_q       <= fv_d;
            err_q      <= err_d;
            to_q       <= to_d;
        end
    end

    assign value       = value_q;
    assign frame_valid = fv_q;
    assign digit_err   = err_q;
    assign stale       = (to_q == TO_MAX);

endmodule

// File: tb/tb_seg_bus_capture.sv
// Directed bench for seg_bus_capture: table of held display patterns plus
// hand sequences for error/clear collision, stale timeout and mid-frame reset.
module tb_seg_bus_capture;

    localparam int STABLE = 4;
    localparam int TMO    = 64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        clr_err;
    logic [15:0] value;
    logic        frame_valid;
    logic [3:0]  digit_err;
    logic        stale;

    always #5 clk = ~clk;

    seg_bus_capture #(.STABLE_CYC(STABLE), .TIMEOUT_CYC(TMO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .an          (an),
        .seg         (seg),
        .clr_err     (clr_err),
        .value       (value),
        .frame_valid (frame_valid),
        .digit_err   (digit_err),
        .stale       (stale)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    int          fv_count = 0;
    int          bad_val_chg = 0;
    logic [15:0] prev_value;

    // Counts frame_valid high cycles and flags value moving without frame_valid.
    always @(posedge clk) begin
        #2;
        if (frame_valid) fv_count++;
        if (rst_n && !frame_valid && (value !== prev_value)) bad_val_chg++;
        prev_value = value;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic drive(input logic [3:0] a, input logic [6:0] s, input int cyc);
        an  = a;
        seg = s;
        repeat (cyc) @(negedge clk);
    endtask

    typedef struct {
        logic [3:0]  an;
        logic [6:0]  seg;
        int          cyc;
        bit          clr;
        int          exp_fv;
        logic [15:0] exp_val;
        logic [3:0]  exp_err;
    } vec_t;

    vec_t vecs[18];

    initial begin
        bit   got;
        logic stale_prev;

        vecs[0]  = '{4'b1110, 7'b1001100,   8, 1'b0, 0, 16'h0000, 4'b0000};
        vecs[1]  = '{4'b1101, 7'b0000110,   8, 1'b0, 0, 16'h0000, 4'b0000};
        vecs[2]  = '{4'b1011, 7'b0010010,   8, 1'b0, 0, 16'h0000, 4'b0000};
        vecs[3]  = '{4'b0111, 7'b1001111,   8, 1'b0, 1, 16'h1234, 4'b0000};
        vecs[4]  = '{4'b1110, 7'b1001111,   8, 1'b0, 1, 16'h1234, 4'b0000};
        vecs[5]  = '{4'b1101, 7'b0010010,   8, 1'b0, 1, 16'h1234, 4'b0000};
        vecs[6]  = '{4'b1011, 7'b0000001,   3, 1'b0, 1, 16'h1234, 4'b0000};
        vecs[7]  = '{4'b0111, 7'b0000110,   8, 1'b0, 1, 16'h1234, 4'b0000};
        vecs[8]  = '{4'b1011, 7'b0100100,   6, 1'b0, 1, 16'h1234, 4'b0000};
        vecs[9]  = '{4'b1111, 7'b1111111,   4, 1'b0, 2, 16'h3521, 4'b0000};
        vecs[10] = '{4'b1101, 7'b1010101,   8, 1'b0, 2, 16'h3521, 4'b0010};
        vecs[11] = '{4'b1110, 7'b0000000,   8, 1'b0, 2, 16'h3521, 4'b0010};
        vecs[12] = '{4'b1011, 7'b0000100,   8, 1'b0, 2, 16'h3521, 4'b0010};
        vecs[13] = '{4'b0111, 7'b0001000,   8, 1'b0, 2, 16'h3521, 4'b0010};
        vecs[14] = '{4'b1111, 7'b1111111,   1, 1'b1, 2, 16'h3521, 4'b0000};
        vecs[15] = '{4'b1101, 7'b0110001,   8, 1'b0, 3, 16'hA9C8, 4'b0000};
        vecs[16] = '{4'b1100, 7'b0000001, 100, 1'b0, 3, 16'hA9C8, 4'b0000};
        vecs[17] = '{4'b1111, 7'b1111111, 100, 1'b0, 3, 16'hA9C8, 4'b0000};

        rst_n   = 1'b0;
        an      = 4'hF;
        seg     = 7'h7F;
        clr_err = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_value", value, 16'h0000);
        check("rst_frame_valid", frame_valid, 1'b0);
        check("rst_digit_err", digit_err, 4'h0);
        check("rst_stale", stale, 1'b0);
        rst_n = 1'b1;

        for (int i = 0; i < 18; i++) begin
            an      = vecs[i].an;
            seg     = vecs[i].seg;
            clr_err = vecs[i].clr;
            repeat (vecs[i].cyc) begin
                @(negedge clk);
                clr_err = 1'b0;
            end
            check($sformatf("vec%0d_frames", i), fv_count, vecs[i].exp_fv);
            check($sformatf("vec%0d_value", i), value, vecs[i].exp_val);
            check($sformatf("vec%0d_err", i), digit_err, vecs[i].exp_err);
        end

        // Illegal capture lands on the same edge as clr_err: the set wins.
        an  = 4'b1101;
        seg = 7'b1010101;
        repeat (5) @(negedge clk);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        check("err_set_beats_clr", digit_err, 4'b0010);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        check("err_cleared", digit_err, 4'b0000);
        check("stale_after_idle", stale, 1'b1);

        // Next frame after a long gap drops stale on the frame_valid edge.
        drive(4'b1110, 7'b0001111, 8);
        drive(4'b1101, 7'b0100000, 8);
        drive(4'b1011, 7'b1111111, 8);
        an  = 4'b0111;
        seg = 7'b0000001;
        got = 1'b0;
        stale_prev = stale;
        for (int c = 0; c < 12 && !got; c++) begin
            stale_prev = stale;
            @(negedge clk);
            if (frame_valid) got = 1'b1;
        end
        check("stale_frame_seen", got, 1'b1);
        check("stale_before_frame", stale_prev, 1'b1);
        check("stale_at_frame", stale, 1'b0);
        check("stale_frame_value", value, 16'h0F67);
        check("stale_frame_count", fv_count, 4);

        // Reset after three digits of a new frame discards them.
        @(negedge clk);
        drive(4'b1110, 7'b0010010, 8);
        drive(4'b1101, 7'b0010010, 8);
        drive(4'b1011, 7'b0010010, 8);
        an  = 4'hF;
        seg = 7'h7F;
        #1 rst_n = 1'b0;
        #1;
        check("midrst_value", value, 16'h0000);
        check("midrst_frame_valid", frame_valid, 1'b0);
        check("midrst_err", digit_err, 4'h0);
        check("midrst_stale", stale, 1'b0);
        @(negedge clk);
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        drive(4'b0111, 7'b0000100, 8);
        check("postrst_no_frame", fv_count, 4);
        check("postrst_value_zero", value, 16'h0000);
        drive(4'b1110, 7'b0100100, 8);
        drive(4'b1101, 7'b0100000, 8);
        drive(4'b1011, 7'b0001111, 8);
        check("postrst_frame_count", fv_count, 5);
        check("postrst_value", value, 16'h9765);
        check("postrst_err", digit_err, 4'h0);

        check("value_only_with_frame_valid", bad_val_chg, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/seg_bus_capture.md
SEG_BUS_CAPTURE -- requirements
Module: seg_bus_capture

Interface
REQ-001 Parameter STABLE_CYC, default 4: consecutive identical synchronized samples required to accept a digit (legal range 2..255).
REQ-002 Parameter TIMEOUT_CYC, default 65536: cycles without a completed frame before stale asserts (legal range 16..2^24).
REQ-003 clk  input  1  single system clock; all state on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 an  input  4  multiplexed digit select, active-low, one-hot when valid; an[0] low selects digit 0, the least-significant nibble.
REQ-006 seg  input  7  segment bus, active-low, bit order {a,b,c,d,e,f,g} = seg[6:0].
REQ-007 clr_err  input  1  synchronous one-cycle clear of digit_err.
REQ-008 value  output  16  last complete captured frame, digit i in value[4*i+3:4*i].
REQ-009 frame_valid  output  1  one-cycle pulse when value updates.
REQ-010 digit_err  output  4  sticky per-digit illegal-pattern flags.
REQ-011 stale  output  1  high while no frame has completed within TIMEOUT_CYC cycles.

Function
REQ-012 an and seg SHALL each pass through a 2-flop synchronizer; all further logic uses synchronized values only.
REQ-013 Decode table (seg -> nibble): 0000001->0, 1001111->1, 0010010->2, 0000110->3, 1001100->4, 0100100->5, 0100000->6, 0001111->7, 0000000->8, 0000100->9, 0001000->A, 1100000->B, 0110001->C, 1000010->D, 0110000->E, 1111111->F (blank decodes as F).
REQ-014 Any other seg pattern SHALL be illegal.
REQ-015 FSM states: IDLE, SETTLE, HOLD.
REQ-016 IDLE: synchronized an not one-hot-low (1111, or two or more bits low); stability counter held at 0.
REQ-017 IDLE->SETTLE when an becomes one-hot-low; counter loads 1.
REQ-018 SETTLE: counter increments while {an,seg} equals the previous sample; on any change counter reloads 1 (or state returns to IDLE if an is no longer one-hot).
REQ-019 SETTLE->HOLD at the edge where the STABLE_CYC-th consecutive identical sample is seen; legal pattern: the digit's nibble register and captured-mask bit set at that edge; illegal pattern: only digit_err bit set, nibble and mask unchanged.
REQ-020 HOLD: no further capture until {an,seg} changes; then SETTLE (counter=1) or IDLE.
REQ-021 A pattern held on the pins for STABLE_CYC+2 cycles SHALL always be captured; one held for fewer than STABLE_CYC cycles SHALL never be captured.
REQ-022 Recapture of an already-masked digit within the same frame SHALL overwrite its nibble.
REQ-023 When captured-mask reaches 4'b1111, the next edge SHALL copy the four nibbles to value, pulse frame_valid for exactly one cycle, and clear the mask; a capture on that same edge SHALL count toward the new frame.
REQ-024 Timeout counter SHALL increment every cycle, clear on frame_valid, and saturate at TIMEOUT_CYC; stale = (counter == TIMEOUT_CYC).
REQ-025 A frame completing on the same cycle the timeout counter reaches TIMEOUT_CYC: frame wins, counter clears, stale stays low.
REQ-026 clr_err clears digit_err; an error setting on the same edge SHALL win (bit stays 1).
REQ-027 value SHALL only change together with frame_valid.

Reset
REQ-028 rst_n low SHALL asynchronously force: synchronizers to an=1111 and seg=1111111, FSM to IDLE, all counters and the mask to 0, nibbles and value to 16'h0000, frame_valid to 0, digit_err to 4'b0000, stale to 0.
REQ-029 Reset asserted mid-frame SHALL discard the partial frame; after release a full four-digit frame is needed for frame_valid.

Verification
REQ-030 Scan an=1110/1101/1011/0111 with seg=1001100 (4), 0000110 (3), 0010010 (2), 1001111 (1), each for 8 cycles -> single frame_valid pulse, value=16'h1234, digit_err=0000.
REQ-031 Same scan, digit 2 held only STABLE_CYC-1 cycles -> no capture of digit 2, no frame_valid until digit 2 is held >=6 cycles.
REQ-032 Digit 1 driven seg=1010101 for 8 cycles -> digit_err=0010, mask unchanged; clr_err pulse -> 0000.
REQ-033 an=1100 or 1111 for 100 cycles -> IDLE, no capture, no error.
REQ-034 No activity for TIMEOUT_CYC cycles -> stale=1; next completed frame -> stale=0 on the frame_valid edge.
REQ-035 rst_n pulsed after 3 of 4 digits captured -> value=0000, no frame_valid until all 4 digits are recaptured.
